// File: rtl/mvm_pkg.sv
// Shared types for the MVM engine arbiter.
package mvm_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_FEED,
    ARB_DRAIN
  } arb_state_t;

  localparam int DATA_W_DEFAULT = 16;

endpackage

// File: rtl/mvm_rr_arbiter_rr_pick.sv
// Rotated priority encoder: first asserted request searching ptr+1, ptr+2, ... (mod NREQ).
module rr_pick #(
  parameter int NREQ = 2,
  parameter int GW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   ptr,
  output logic            any,
  output logic [GW-1:0]   idx
);

  // Walk from the lowest priority slot upward so the highest priority hit is written last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        any = 1'b1;
        idx = GW'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/mvm_rr_arbiter.sv
// Round-robin sharing of one MVM engine among NREQ requesters, one whole job per grant.
module mvm_rr_arbiter
  import mvm_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int N      = 8,
  parameter int M      = 6,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NREQ-1:0]               req_s_valid,
  input  logic [NREQ-1:0][DATA_W-1:0]   req_data_in,
  output logic [NREQ-1:0]               req_s_ready,
  output logic [NREQ-1:0]               req_m_valid,
  output logic [NREQ-1:0][DATA_W-1:0]   req_data_out,
  input  logic [NREQ-1:0]               req_m_ready,
  output logic                          eng_s_valid,
  output logic signed [DATA_W-1:0]      eng_data_in,
  input  logic                          eng_s_ready,
  input  logic                          eng_m_valid,
  input  logic signed [DATA_W-1:0]      eng_data_out,
  output logic                          eng_m_ready,
  output logic [$clog2(NREQ)-1:0]       grant_id,
  output logic                          busy
);

  localparam int GW = $clog2(NREQ);
  localparam int IW = $clog2(N);
  localparam int OW = $clog2(M);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] in_cnt, in_cnt_nxt;
  logic [OW-1:0] out_cnt, out_cnt_nxt;
  logic [GW-1:0] rr_ptr, rr_ptr_nxt;
  logic [GW-1:0] grant_nxt;
  logic          pick_any;
  logic [GW-1:0] pick_idx;
  logic          feed, drain;
  logic          in_beat, out_beat;

  rr_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_pick (
    .req  (req_s_valid),
    .ptr  (rr_ptr),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign feed  = (state == ARB_FEED);
  assign drain = (state == ARB_DRAIN);
  assign busy  = (state != ARB_IDLE);

  // Engine side is a pure mux of the granted requester; idle directions are held at zero.
  assign eng_s_valid = feed & req_s_valid[grant_id];
  assign eng_data_in = feed ? req_data_in[grant_id] : '0;
  assign eng_m_ready = drain & req_m_ready[grant_id];

  assign in_beat  = eng_s_valid & eng_s_ready;
  assign out_beat = eng_m_valid & eng_m_ready;

  // One-hot demux back to the requesters; only the granted slot ever sees the engine.
  for (genvar r = 0; r < NREQ; r++) begin : g_demux
    logic sel;
    assign sel             = (grant_id == GW'(r));
    assign req_s_ready[r]  = feed & sel & eng_s_ready;
    assign req_m_valid[r]  = drain & sel & eng_m_valid;
    assign req_data_out[r] = (drain & sel) ? eng_data_out : '0;
  end

  // Control registers: state, beat counters, grant and rotation pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ARB_IDLE;
      in_cnt   <= '0;
      out_cnt  <= '0;
      grant_id <= '0;
      rr_ptr   <= GW'(NREQ - 1);
    end else begin
      state    <= state_nxt;
      in_cnt   <= in_cnt_nxt;
      out_cnt  <= out_cnt_nxt;
      grant_id <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
    end
  end

  // Next-state: pick in IDLE, count N beats in, count M beats out, then rotate priority.
  always_comb begin
    state_nxt   = state;
    in_cnt_nxt  = in_cnt;
    out_cnt_nxt = out_cnt;
    grant_nxt   = grant_id;
    rr_ptr_nxt  = rr_ptr;
    unique case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_nxt  = pick_idx;
          in_cnt_nxt = '0;
          state_nxt  = ARB_FEED;
        end
      end
      ARB_FEED: begin
        if (in_beat) begin
          if (in_cnt == IW'(N - 1)) begin
            in_cnt_nxt  = '0;
            out_cnt_nxt = '0;
            state_nxt   = ARB_DRAIN;
          end else begin
            in_cnt_nxt = in_cnt + IW'(1);
          end
        end
      end
      ARB_DRAIN: begin
        if (out_beat) begin
          if (out_cnt == OW'(M - 1)) begin
            out_cnt_nxt = '0;
            rr_ptr_nxt  = grant_id;
            state_nxt   = ARB_IDLE;
          end else begin
            out_cnt_nxt = out_cnt + OW'(1);
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mvm_rr_arbiter.sv
// Randomized scoreboard bench for mvm_rr_arbiter with a behavioural engine stand-in.
module tb_mvm_rr_arbiter;

  localparam int NREQ   = 2;
  localparam int N      = 8;
  localparam int M      = 6;
  localparam int DATA_W = 16;
  localparam int GW     = $clog2(NREQ);

  typedef logic signed [DATA_W-1:0] word_t;
  typedef word_t vec_t [N];

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NREQ-1:0]             req_s_valid;
  logic [NREQ-1:0][DATA_W-1:0] req_data_in;
  logic [NREQ-1:0]             req_s_ready;
  logic [NREQ-1:0]             req_m_valid;
  logic [NREQ-1:0][DATA_W-1:0] req_data_out;
  logic [NREQ-1:0]             req_m_ready;
  logic                        eng_s_valid;
  logic [DATA_W-1:0]           eng_data_in;
  logic                        eng_s_ready;
  logic                        eng_m_valid;
  logic [DATA_W-1:0]           eng_data_out;
  logic                        eng_m_ready;
  logic [GW-1:0]               grant_id;
  logic                        busy;

  int n_vec = 0;
  int n_err = 0;

  word_t exp_q [NREQ][$];

  mvm_rr_arbiter #(.NREQ(NREQ), .N(N), .M(M), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_s_valid  (req_s_valid),
    .req_data_in  (req_data_in),
    .req_s_ready  (req_s_ready),
    .req_m_valid  (req_m_valid),
    .req_data_out (req_data_out),
    .req_m_ready  (req_m_ready),
    .eng_s_valid  (eng_s_valid),
    .eng_data_in  (eng_data_in),
    .eng_s_ready  (eng_s_ready),
    .eng_m_valid  (eng_m_valid),
    .eng_data_out (eng_data_out),
    .eng_m_ready  (eng_m_ready),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Layer function of the engine: fixed small integer weights followed by ReLU.
  function automatic word_t layer_ref(input vec_t x, input int j);
    int acc;
    acc = 0;
    for (int i = 0; i < N; i++) acc += int'(x[i]) * ((((i * 3) + (j * 5)) % 7) - 3);
    return (acc < 0) ? word_t'(0) : word_t'(acc);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus: requesters, consumers and engine stand-in ----------------
  vec_t cur_x [NREQ];
  int   jobs_left [NREQ];
  int   beat_idx [NREQ];
  int   pause [NREQ];
  int   hold [NREQ];
  bit   loaded [NREQ];
  bit   dropped [NREQ];
  vec_t eng_buf;
  word_t eng_res [M];
  int   eng_in_n, eng_out_n;
  bit   eng_draining;

  task automatic load_job(input int r);
    for (int i = 0; i < N; i++) cur_x[r][i] = word_t'(int'($urandom_range(200)) - 100);
    for (int j = 0; j < M; j++) exp_q[r].push_back(layer_ref(cur_x[r], j));
    loaded[r]   = 1'b1;
    beat_idx[r] = 0;
    dropped[r]  = 1'b0;
  endtask

  task automatic run_phase(input int j0, input int j1, input int gap_pct, input int rdy_pct,
                           input int drop_r, input int hold_r, input int rst_beat, input int budget);
    int cyc;
    bit done, rst_done, held_done;
    cyc = 0; done = 1'b0; rst_done = 1'b0; held_done = 1'b0;
    jobs_left[0] = j0;
    jobs_left[1] = j1;
    for (int r = 0; r < NREQ; r++) begin
      loaded[r] = 1'b0; pause[r] = 0; hold[r] = 0;
      if (jobs_left[r] > 0) load_job(r);
    end
    while (!done) begin
      @(negedge clk);
      if (reset) reset = 1'b0;
      else if (rst_beat >= 0 && !rst_done && loaded[0] && beat_idx[0] == rst_beat) begin
        reset = 1'b1; rst_done = 1'b1;
      end
      for (int r = 0; r < NREQ; r++) begin
        if (r == drop_r && loaded[r] && beat_idx[r] == 4 && !dropped[r]) begin
          pause[r] = 3; dropped[r] = 1'b1;
        end
        req_data_in[r] = DATA_W'($urandom);
        if (pause[r] > 0) begin
          req_s_valid[r] = 1'b0; pause[r]--;
        end else if (loaded[r] && !reset && int'($urandom_range(99)) >= gap_pct) begin
          req_s_valid[r] = 1'b1; req_data_in[r] = cur_x[r][beat_idx[r]];
        end else begin
          req_s_valid[r] = 1'b0;
        end
        if (hold[r] > 0) begin
          req_m_ready[r] = 1'b0; hold[r]--;
        end else begin
          req_m_ready[r] = (int'($urandom_range(99)) < rdy_pct);
        end
      end
      if (eng_draining && !reset) begin
        eng_s_ready = 1'b0; eng_m_valid = 1'b1; eng_data_out = eng_res[eng_out_n];
      end else begin
        eng_s_ready = !reset && ($urandom_range(3) != 0);
        eng_m_valid = 1'b0; eng_data_out = DATA_W'($urandom);
      end
      #1;
      if (reset) begin
        eng_draining = 1'b0; eng_in_n = 0; eng_out_n = 0;
        for (int r = 0; r < NREQ; r++) begin beat_idx[r] = 0; pause[r] = 0; end
      end else begin
        if (!eng_draining) begin
          if (eng_s_valid && eng_s_ready) begin
            eng_buf[eng_in_n] = word_t'(eng_data_in);
            eng_in_n++;
            if (eng_in_n == N) begin
              for (int j = 0; j < M; j++) eng_res[j] = layer_ref(eng_buf, j);
              eng_draining = 1'b1; eng_out_n = 0;
            end
          end
        end else if (eng_m_valid && eng_m_ready) begin
          eng_out_n++;
          if (eng_out_n == M) begin eng_draining = 1'b0; eng_in_n = 0; end
        end
        for (int r = 0; r < NREQ; r++) begin
          if (req_s_valid[r] && req_s_ready[r]) begin
            beat_idx[r]++;
            if (beat_idx[r] == N) begin
              jobs_left[r]--; loaded[r] = 1'b0;
              if (jobs_left[r] > 0) load_job(r);
            end
          end
        end
        if (hold_r >= 0 && !held_done && req_m_valid[hold_r]) begin
          hold[hold_r] = 5; held_done = 1'b1;
        end
      end
      cyc++;
      done = !busy && !eng_draining && !reset;
      for (int r = 0; r < NREQ; r++)
        if (loaded[r] || jobs_left[r] > 0 || exp_q[r].size() > 0) done = 1'b0;
      if (!done && cyc >= budget) begin
        chk("phase_completed", longint'(done), 1);
        done = 1'b1;
      end
    end
    @(negedge clk);
    req_s_valid = '0;
    req_m_ready = '0;
  endtask

  initial begin : stimulus
    reset = 1'b1;
    req_s_valid = '0; req_data_in = '0; req_m_ready = '0;
    eng_s_ready = 1'b0; eng_m_valid = 1'b0; eng_data_out = '0;
    eng_draining = 1'b0; eng_in_n = 0; eng_out_n = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    // single requester job
    run_phase(1, 0, 0, 100, -1, -1, -1, 500);
    // tie after reset, then continuous alternation for four jobs each
    run_phase(4, 4, 0, 100, -1, -1, -1, 1500);
    // requester 1 pauses three cycles after its fourth beat
    run_phase(1, 1, 0, 100, 1, -1, -1, 500);
    // requester 0 stalls results for five cycles while requester 1 waits
    run_phase(1, 1, 0, 100, -1, 0, -1, 500);
    // reset in the middle of feeding, then the job is replayed from the start
    run_phase(1, 0, 0, 100, -1, -1, 5, 500);
    // random gaps on both sides
    run_phase(6, 6, 25, 70, -1, -1, -1, 3000);
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- monitor: grant model, isolation checks and result scoreboard ----------------
  initial begin : monitor
    int    g_model, ptr_model, pick;
    bit    pick_pend;
    bit    stall [NREQ];
    word_t stall_d [NREQ];
    word_t exp;
    g_model = 0; ptr_model = NREQ - 1; pick_pend = 1'b0;
    for (int r = 0; r < NREQ; r++) begin stall[r] = 1'b0; stall_d[r] = '0; end
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        chk("rst_busy", longint'(busy), 0);
        chk("rst_grant_id", longint'(grant_id), 0);
        chk("rst_eng_s_valid", longint'(eng_s_valid), 0);
        chk("rst_eng_m_ready", longint'(eng_m_ready), 0);
        chk("rst_eng_data_in", longint'(eng_data_in), 0);
        chk("rst_req_s_ready", longint'(req_s_ready), 0);
        chk("rst_req_m_valid", longint'(req_m_valid), 0);
        chk("rst_req_data_out", longint'(req_data_out), 0);
        g_model = 0; ptr_model = NREQ - 1; pick_pend = 1'b0;
        for (int r = 0; r < NREQ; r++) stall[r] = 1'b0;
      end else begin
        if (pick_pend) begin
          chk("one_bubble_then_busy", longint'(busy), 1);
          pick_pend = 1'b0;
        end
        chk("grant_id", longint'(grant_id), longint'(g_model));
        if (!busy) begin
          chk("idle_req_s_ready", longint'(req_s_ready), 0);
          chk("idle_req_m_valid", longint'(req_m_valid), 0);
          chk("idle_eng_s_valid", longint'(eng_s_valid), 0);
          chk("idle_eng_m_ready", longint'(eng_m_ready), 0);
          chk("idle_eng_data_in", longint'(eng_data_in), 0);
          if (req_s_valid != '0) begin
            pick = -1;
            for (int k = 1; k <= NREQ; k++)
              if (pick < 0 && req_s_valid[(ptr_model + k) % NREQ]) pick = (ptr_model + k) % NREQ;
            g_model = pick; ptr_model = pick; pick_pend = 1'b1;
          end
        end else begin
          for (int r = 0; r < NREQ; r++) begin
            if (r != g_model) begin
              chk($sformatf("ungranted_s_ready_req%0d", r), longint'(req_s_ready[r]), 0);
              chk($sformatf("ungranted_m_valid_req%0d", r), longint'(req_m_valid[r]), 0);
              chk($sformatf("ungranted_data_out_req%0d", r), longint'(req_data_out[r]), 0);
            end
          end
        end
        for (int r = 0; r < NREQ; r++) begin
          if (stall[r]) begin
            chk($sformatf("held_m_valid_req%0d", r), longint'(req_m_valid[r]), 1);
            chk($sformatf("held_data_req%0d", r), longint'(word_t'(req_data_out[r])), longint'(stall_d[r]));
          end
          stall[r]   = req_m_valid[r] && !req_m_ready[r];
          stall_d[r] = word_t'(req_data_out[r]);
          if (req_m_valid[r] && req_m_ready[r]) begin
            chk($sformatf("result_expected_req%0d", r), longint'(exp_q[r].size() > 0), 1);
            if (exp_q[r].size() > 0) begin
              exp = exp_q[r].pop_front();
              chk($sformatf("result_req%0d", r), longint'(word_t'(req_data_out[r])), longint'(exp));
            end
          end
        end
      end
    end
  end

endmodule
